// File: rtl/counter_pkg.sv
// Shared definitions for the cascaded digit counter: width helpers,
// direction encoding and the per-digit action type.
package counter_pkg;

    // Direction encoding as seen on the up input.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // What a single digit cell does on the next edge.
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_INC  = 2'd2,
        ACT_DEC  = 2'd3
    } digit_act_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Bit width of one digit of the given radix; never less than one bit.
    function automatic int digit_width(input int radix);
        int w;
        w = clog2(radix);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : counter_pkg

// File: rtl/counter_digit.sv
// One digit of the cascaded up/down counter. Steps modulo RADIX when
// enabled, loads a pre-clamped value, and reports whether it sits at its
// carry (RADIX-1) or borrow (0) limit so the top can build the enable chain.
module counter_digit
    import counter_pkg::*;
#(
    parameter  int RADIX = 10,
    localparam int DW    = digit_width(RADIX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          up,
    input  logic          load,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] q,
    output logic          at_max,
    output logic          at_min
);

    localparam logic [DW-1:0] MAX_CODE = DW'(RADIX - 1);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;
    digit_act_e    act;

    // Choose the digit action: load wins over stepping.
    always_comb begin
        // NOTE: every signal written in always_comb is given a default first so no latch is inferred.
        act = ACT_HOLD;
        if (load) begin
            act = ACT_LOAD;
        end else if (step) begin
            act = (up == DIR_UP) ? ACT_INC : ACT_DEC;
        end
    end

    // Next digit value, wrapping at both ends of the radix range.
    always_comb begin
        q_d = q_q;
        unique case (act)
            ACT_LOAD: q_d = din;
            ACT_INC:  q_d = at_max ? '0 : q_q + 1'b1;
            ACT_DEC:  q_d = at_min ? MAX_CODE : q_q - 1'b1;
            default:  q_d = q_q;
        endcase
    end

    // Digit register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign at_max = (q_q == MAX_CODE);
    assign at_min = (q_q == '0);

endmodule : counter_digit

// File: rtl/digit_updown_counter.sv
// Parametrised multi-digit up/down counter built from cascaded
// counter_digit cells. The top owns load clamping, the carry/borrow enable
// chain, terminal count and the registered wrap pulse.
// Optional build macro DIGIT_COUNTER_SATURATE_EN: the counter holds at
// terminal count instead of rolling over, wrap is tied low and an extra
// combinational output sat = tc & t is provided.
module digit_updown_counter
    import counter_pkg::*;
#(
    parameter  int DIGITS = 4,
    parameter  int RADIX  = 10,
    localparam int DW     = digit_width(RADIX)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 t,
    input  logic                 up,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] q,
    output logic                 tc,
    output logic                 wrap
`ifdef DIGIT_COUNTER_SATURATE_EN
    ,
    output logic                 sat
`endif
);

    localparam logic [DW-1:0] MAX_CODE = DW'(RADIX - 1);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] en_chain;
    logic [DIGITS-1:0] step;
    logic              hold_at_limit;
    logic              wrap_q;
    logic              wrap_d;

    // Terminal count: every digit at the limit that the current direction rolls over from.
    assign tc = (up == DIR_DN) ? (&at_min) : (&at_max);

`ifdef DIGIT_COUNTER_SATURATE_EN
    assign hold_at_limit = t & tc;
    assign sat           = t & tc;
`else
    assign hold_at_limit = 1'b0;
`endif

    // Enable chain: a digit steps when t is high and every lower digit sits at its limit.
    always_comb begin
        en_chain    = '0;
        en_chain[0] = t;
        for (int i = 1; i < DIGITS; i++) begin
            en_chain[i] = en_chain[i-1] &
                          ((up == DIR_UP) ? at_max[i-1] : at_min[i-1]);
        end
    end

    // Load and saturation both suppress counting for the whole counter.
    assign step = en_chain & {DIGITS{~load & ~hold_at_limit}};

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            logic [DW-1:0] raw_din;
            logic [DW-1:0] din_clamped;

            // Codes at or above RADIX cannot be represented; pin them to the top digit value.
            assign raw_din     = load_val[g*DW +: DW];
            assign din_clamped = (int'(raw_din) >= RADIX) ? MAX_CODE : raw_din;

            counter_digit #(
                .RADIX (RADIX)
            ) u_digit (
                .clk    (clk),
                .reset  (reset),
                .step   (step[g]),
                .up     (up),
                .load   (load),
                .din    (din_clamped),
                .q      (q[g*DW +: DW]),
                .at_max (at_max[g]),
                .at_min (at_min[g])
            );
        end
    endgenerate

    // Wrap fires when a counting edge leaves the terminal value; load or hold clears it.
    always_comb begin
        wrap_d = 1'b0;
`ifndef DIGIT_COUNTER_SATURATE_EN
        wrap_d = t & tc & ~load;
`endif
    end

    // Registered wrap pulse, aligned with the wrapped q value.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule : digit_updown_counter

// File: tb/tb_digit_updown_counter.sv
// Directed self-checking bench for digit_updown_counter: a two-digit BCD
// instance plus a three-digit binary instance, with hand-computed
// expectations for both the wrapping and the saturating build.
`timescale 1ns/1ps
module tb_digit_updown_counter;

`ifdef DIGIT_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // BCD pair: DIGITS=2, RADIX=10, DW=4
    logic       a_reset, a_t, a_up, a_load;
    logic [7:0] a_load_val, a_q;
    logic       a_tc, a_wrap;
`ifdef DIGIT_COUNTER_SATURATE_EN
    logic       a_sat;
`endif

    // Binary triple: DIGITS=3, RADIX=2, DW=1
    logic       b_reset, b_t, b_up, b_load;
    logic [2:0] b_load_val, b_q;
    logic       b_tc, b_wrap;
`ifdef DIGIT_COUNTER_SATURATE_EN
    logic       b_sat;
`endif

    digit_updown_counter #(.DIGITS(2), .RADIX(10)) u_dut_a (
        .clk      (clk),
        .reset    (a_reset),
        .t        (a_t),
        .up       (a_up),
        .load     (a_load),
        .load_val (a_load_val),
        .q        (a_q),
        .tc       (a_tc),
        .wrap     (a_wrap)
`ifdef DIGIT_COUNTER_SATURATE_EN
        ,
        .sat      (a_sat)
`endif
    );

    digit_updown_counter #(.DIGITS(3), .RADIX(2)) u_dut_b (
        .clk      (clk),
        .reset    (b_reset),
        .t        (b_t),
        .up       (b_up),
        .load     (b_load),
        .load_val (b_load_val),
        .q        (b_q),
        .tc       (b_tc),
        .wrap     (b_wrap)
`ifdef DIGIT_COUNTER_SATURATE_EN
        ,
        .sat      (b_sat)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic rst, input logic tt, input logic u,
                           input logic ld, input logic [7:0] lv);
        a_reset = rst; a_t = tt; a_up = u; a_load = ld; a_load_val = lv;
    endtask

    initial begin
        a_drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        b_reset = 1'b1; b_t = 1'b0; b_up = 1'b1; b_load = 1'b0; b_load_val = 3'b000;
        tick();

        // Reset state; tc follows up combinationally.
        check("rst_q", a_q, 8'h00);
        check("rst_wrap", a_wrap, 1'b0);
        check("rst_tc_up", a_tc, 1'b0);
        a_up = 1'b0; #1;
        check("rst_tc_dn", a_tc, 1'b1);

        // Count up ten steps: 00 -> 10, wrap never set.
        a_drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("up10_wrap", a_wrap, 1'b0);
        end
        check("up10_q", a_q, 8'h10);

        // Reset while t is still high.
        a_reset = 1'b1;
        tick();
        check("rst2_q", a_q, 8'h00);
        check("rst2_wrap", a_wrap, 1'b0);

        // Load 98 then count through 99 and roll over.
        a_drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h98);
        tick();
        check("ld98_q", a_q, 8'h98);
        a_drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        check("e1_q", a_q, 8'h99);
        check("e1_tc", a_tc, 1'b1);
        check("e1_wrap", a_wrap, 1'b0);
`ifdef DIGIT_COUNTER_SATURATE_EN
        check("sat_flag", a_sat, 1'b1);
`endif
        tick();
        check("e2_q", a_q, SAT ? 8'h99 : 8'h00);
        check("e2_wrap", a_wrap, SAT ? 1'b0 : 1'b1);
        tick();
        check("e3_q", a_q, SAT ? 8'h99 : 8'h01);
        check("e3_wrap", a_wrap, 1'b0);

        // From reset, one down-step borrows through both digits.
        a_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        a_drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        check("dn_q", a_q, SAT ? 8'h00 : 8'h99);
        check("dn_wrap", a_wrap, SAT ? 1'b0 : 1'b1);

        // Hold for three cycles.
        a_t = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_q", a_q, SAT ? 8'h00 : 8'h99);
            check("hold_wrap", a_wrap, 1'b0);
        end

        // Load with t high: both digits clamp, counting ignored.
        a_drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hFA);
        tick();
        check("clamp_both", a_q, 8'h99);
        check("clamp_wrap", a_wrap, 1'b0);
        a_drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hC3);
        tick();
        check("clamp_hi", a_q, 8'h93);

        // Reset dominates load and t on the same edge.
        a_drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h42);
        tick();
        check("rst_prio", a_q, 8'h00);

        // Direction toggled every edge from 50.
        a_drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h50);
        tick();
        a_drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tick(); check("tog1", a_q, 8'h51);
        a_up = 1'b0;
        tick(); check("tog2", a_q, 8'h50);
        a_up = 1'b1;
        tick(); check("tog3", a_q, 8'h51);
        a_up = 1'b0;
        tick(); check("tog4", a_q, 8'h50);

        // Single borrow across the digit boundary.
        a_drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h40);
        tick();
        a_drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        check("borrow_q", a_q, 8'h39);
        check("borrow_wrap", a_wrap, 1'b0);

        // Binary counter: eight up-steps from zero.
        b_reset = 1'b0; b_t = 1'b1; b_up = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) check("b_q7", b_q, 3'b111);
            if (i < 8)  check("b_wrap_pre", b_wrap, 1'b0);
        end
        check("b_q8", b_q, SAT ? 3'b111 : 3'b000);
        check("b_wrap8", b_wrap, SAT ? 1'b0 : 1'b1);
        b_load = 1'b1; b_load_val = 3'b101; b_t = 1'b0;
        tick();
        check("b_load", b_q, 3'b101);
        check("b_tc_up", b_tc, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_digit_updown_counter
